cart_sav_io: RTL
================

// Module: cart_sav_io
// PURPOSE
// Backup-RAM save/load engine for the cartridge RAM (cram) of the Game Boy cart.
// Moves cram contents to and from the HPS SD image in 512-byte blocks.
// Uses the spare port B of the two 8-bit cram halves (lo = even byte, hi = odd byte) as one 16-bit word port.
// Sits between the cart RAM and the HPS sd_* block interface; tracks dirty state so saves happen only when needed.
// PARAMETERS
// TIMEOUT_W  24  width of the ack-wait timeout counter; abort after 2**TIMEOUT_W-1 cycles with no sd_ack
// PORTS
// clk_sys        in   1   system clock, all logic on rising edge
// reset_n        in   1   asynchronous active-low reset
// cart_ram_size  in   8   header RAM size code 0..4
// mbc2           in   1   cart is MBC2 (512x4 internal RAM)
// mbc_battery    in   1   cart has battery-backed RAM
// img_mounted    in   1   pulse: save image (re)mounted
// img_readonly   in   1   mounted image is read-only
// img_size       in   32  mounted image size in bytes
// bk_load        in   1   pulse: request load from SD
// bk_save        in   1   pulse: request save to SD
// cpu_cram_wr    in   1   CPU write strobe into cram (sets dirty)
// sd_lba         out  32  block number of current transfer
// sd_rd          out  1   block read request to HPS
// sd_wr          out  1   block write request to HPS
// sd_ack         in   1   HPS acknowledge, high for duration of block
// sd_buff_addr   in   8   word index within block (0..255)
// sd_buff_dout   in   16  word from HPS (load)
// sd_buff_wr     in   1   sd_buff_dout valid strobe
// sd_buff_din    out  16  word to HPS (save) = cram_b_q
// cram_b_addr    out  16  cram port-B word address
// cram_b_wren    out  1   cram port-B write enable (both halves)
// cram_b_data    out  16  cram port-B write data {hi,lo}
// cram_b_q       in   16  cram port-B read data, 1-cycle latency
// busy           out  1   transfer in progress; cart holds CPU cram access
// dirty          out  1   cram modified since last load/save
// error          out  1   sticky: last transfer timed out; cleared on next accepted request
// BEHAVIOUR
// - Reset: state IDLE; sd_rd=sd_wr=0, sd_lba=0, cram_b_wren=0, busy=0, dirty=0, error=0.
// - Reset mid-transfer: immediate return to IDLE with all outputs at reset values; partial data is not rolled back.
// - Block count N: mbc2->1; ram_size 1->4, 2->16, 3->64, 4->256; 0 and !mbc2 -> 0 (no RAM).
// - sav_ok = mbc_battery & (N!=0) & mounted; mounted set by img_mounted with img_size!=0, cleared by img_mounted with img_size==0.
// - img_mounted with img_size!=0 and sav_ok queues an automatic load.
// - Request acceptance, IDLE only:
//   - load accepted if sav_ok.
//   - save accepted if sav_ok & !img_readonly & dirty.
//   - load wins if both arrive in the same cycle; requests while busy are dropped.
// - States:
//   - IDLE -> REQ on accept: blk=0, error=0, dirty cleared at accept (save and load).
//   - REQ: sd_lba={24'd0,blk}; assert sd_rd (load) or sd_wr (save); timeout counter runs; -> XFER when sd_ack=1.
//   - XFER: deassert sd_rd/sd_wr.
//     - Load: on sd_buff_wr, cram_b_addr={blk,sd_buff_addr}, cram_b_data=sd_buff_dout, cram_b_wren=1 for exactly that cycle.
//     - Save: cram_b_addr={blk,sd_buff_addr} registered; sd_buff_din=cram_b_q (2-cycle addr-to-data).
//     - -> NEXT on sd_ack falling.
//   - NEXT: if blk==N-1 -> IDLE, else blk+1 -> REQ.
//   - Timeout: counter saturates in REQ -> IDLE, error=1, dirty restored to 1 if a save was aborted.
// - busy=1 in every state except IDLE.
// - blk is 8 bits and never wraps past N-1.
// - cram_b_addr upper bits beyond the RAM size are forced to 0.
// - dirty: set by cpu_cram_wr in any cycle except the accept cycle of a request; during a save, dirty set again by a CPU write stays set after completion.
// - All outputs registered; sd_rd/sd_wr rise 1 cycle after acceptance.
// TESTING
// - ram_size=3, battery, mounted, 1 CPU write, bk_save -> 64 sd_wr handshakes, lba 0..63, dirty=0, busy drops after block 63.
// - ram_size=2 load, HPS writes 0xA55A at buff_addr 5 of lba 3 -> cram_b_wren at word 0x0305 with data 0xA55A.
// - bk_load and bk_save same cycle -> only sd_rd asserted.
// - img_readonly=1, dirty=1, bk_save -> ignored: busy stays 0, no sd_wr.
// - sd_ack never rises with TIMEOUT_W=4 -> after 15 cycles in REQ: IDLE, error=1, dirty=1.
// - reset_n low mid-XFER of block 7 -> next edge: sd_rd=sd_wr=0, busy=0, cram_b_wren=0.

Source files
------------

// File: rtl/cart_sav_io_if.sv
// SD block-transfer link between the save engine and the HPS image server.
//
// Handshake: the engine raises exactly one of sd_rd/sd_wr as a block request
// (valid) with sd_lba stable, and holds it until it sees sd_ack (ready) high.
// It then drops the request, and sd_ack stays high for the whole 256-word
// block. The words move on sd_buff_addr/sd_buff_dout/sd_buff_wr (load) or on
// sd_buff_addr/sd_buff_din (save). The falling edge of sd_ack ends the block.
interface cart_sav_io_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din;

  // Engine side: issues block requests, sources save data.
  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  // HPS side: acknowledges blocks, sources load data.
  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/cart_sav_io.sv
// Backup-RAM save/load engine. It moves cartridge RAM to and from the SD save
// image in 512-byte blocks through cram port B, seen here as one 16-bit word
// port. A dirty flag makes sure saves only happen after the RAM has changed.
module cart_sav_io #(
  parameter int TIMEOUT_W = 24
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [7:0]  cart_ram_size,
  input  logic        mbc2,
  input  logic        mbc_battery,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [31:0] img_size,
  input  logic        bk_load,
  input  logic        bk_save,
  input  logic        cpu_cram_wr,
  cart_sav_io_if.master sd,
  output logic [15:0] cram_b_addr,
  output logic        cram_b_wren,
  output logic [15:0] cram_b_data,
  input  logic [15:0] cram_b_q,
  output logic        busy,
  output logic        dirty,
  output logic        error,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_NEXT} state_t;

  // The abort happens on the cycle the counter would reach all-ones, which
  // gives 2**TIMEOUT_W-1 cycles of waiting in REQ.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [TIMEOUT_W-1:0] TMO_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [7:0]           blk_q, blk_d;
  logic                 save_q, save_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic                 mounted_q;
  logic                 load_pend_q;

  logic [7:0]  blk_last;
  logic        has_ram;
  logic        sav_ok;
  logic        accept_load;
  logic        accept_save;
  logic        timeout;
  logic        buff_phase;
  logic [15:0] word_addr;

  // Last block index from the header. Block counts are powers of two, so the
  // same value also masks the block bits of the cram word address.
  always_comb begin
    blk_last = 8'd0;
    has_ram  = 1'b1;
    if (!mbc2) begin
      case (cart_ram_size)
        8'd1:    blk_last = 8'd3;
        8'd2:    blk_last = 8'd15;
        8'd3:    blk_last = 8'd63;
        8'd4:    blk_last = 8'd255;
        default: has_ram  = 1'b0;
      endcase
    end
  end

  assign sav_ok     = mbc_battery & has_ram & mounted_q;
  assign buff_phase = (state_q == S_XFER) || ((state_q == S_REQ) && sd.sd_ack);
  assign word_addr  = {blk_q & blk_last, sd.sd_buff_addr};
  assign dbg_state  = state_q;

  // Save data goes straight from the RAM output register, so a word appears
  // two cycles after its sd_buff_addr.
  assign sd.sd_buff_din = cram_b_q;

  // FSM state and transfer bookkeeping registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      blk_q   <= 8'd0;
      save_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      save_q  <= save_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state: request acceptance, block ack tracking, timeout, block stepping.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    save_d      = save_q;
    tmo_d       = tmo_q;
    accept_load = 1'b0;
    accept_save = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((bk_load || load_pend_q) && sav_ok)
          accept_load = 1'b1;
        else if (bk_save && sav_ok && !img_readonly && dirty)
          accept_save = 1'b1;
        if (accept_load || accept_save) begin
          state_d = S_REQ;
          blk_d   = 8'd0;
          save_d  = accept_save;
          tmo_d   = '0;
        end
      end
      S_REQ: begin
        if (sd.sd_ack) begin
          state_d = S_XFER;
        end else if (tmo_q == TMO_LAST) begin
          timeout = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end
      S_XFER: begin
        if (!sd.sd_ack) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (blk_q >= blk_last) begin
          state_d = S_IDLE;
        end else begin
          blk_d   = blk_q + 8'd1;
          tmo_d   = '0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered SD request and cram port-B outputs, derived from next state.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sd.sd_rd    <= 1'b0;
      sd.sd_wr    <= 1'b0;
      sd.sd_lba   <= 32'd0;
      busy        <= 1'b0;
      cram_b_wren <= 1'b0;
      cram_b_addr <= 16'd0;
      cram_b_data <= 16'd0;
    end else begin
      sd.sd_rd    <= (state_d == S_REQ) && !save_d;
      sd.sd_wr    <= (state_d == S_REQ) && save_d;
      busy        <= (state_d != S_IDLE);
      if (state_d == S_REQ) sd.sd_lba <= {24'd0, blk_d};
      cram_b_wren <= 1'b0;
      if (buff_phase) begin
        if (save_q) begin
          cram_b_addr <= word_addr;
        end else if (sd.sd_buff_wr) begin
          cram_b_wren <= 1'b1;
          cram_b_addr <= word_addr;
          cram_b_data <= sd.sd_buff_dout;
        end
      end
    end
  end

  // Mount tracking, queued auto-load, dirty and sticky error flags.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      mounted_q   <= 1'b0;
      load_pend_q <= 1'b0;
      dirty       <= 1'b0;
      error       <= 1'b0;
    end else begin
      if (img_mounted) begin
        mounted_q   <= (img_size != 32'd0);
        load_pend_q <= (img_size != 32'd0) && mbc_battery && has_ram;
      end else if (accept_load) begin
        load_pend_q <= 1'b0;
      end

      // A CPU write on the accept cycle is folded into the transfer.
      if (accept_load || accept_save)
        dirty <= 1'b0;
      else if ((timeout && save_q) || cpu_cram_wr)
        dirty <= 1'b1;

      if (accept_load || accept_save)
        error <= 1'b0;
      else if (timeout)
        error <= 1'b1;
    end
  end

endmodule
